// File: rtl/zx_mmap_ext.sv
// ZX Spectrum 128K / Pentagon / +3 memory and port mapper: CPU-to-array address
// translation, 7FFD/1FFD/border registers and TR-DOS ROM auto-switching.
module zx_mmap_ext #(
    parameter int BANK_BITS = 3,
    parameter bit PLUS3_EN  = 1'b0,
    parameter bit TRDOS_EN  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   m0,
    input  logic                   hold,
    input  logic [15:0]            address,
    input  logic                   we,
    input  logic                   portwe,
    input  logic [7:0]             o_data,
    input  logic [7:0]             rom_idata,
    input  logic [7:0]             trdos_idata,
    input  logic [7:0]             ram_idata,
    output logic [7:0]             i_data,
    output logic [15:0]            rom_address,
    output logic [13+BANK_BITS:0]  ram_address,
    output logic                   ram_we,
    output logic [7:0]             port_rdata,
    output logic                   port_hit,
    output logic                   vidpage,
    output logic [2:0]             border,
    output logic                   trdos
);

    typedef enum logic {ST_NORMAL, ST_DOS} trdos_state_t;

    localparam logic [1:0] ROM_TOP = PLUS3_EN ? 2'd3 : 2'd1;

    logic [7:0]           p7ffd;
    logic [7:0]           p1ffd;
    logic                 pw_q;
    trdos_state_t         state;

    logic [1:0]           quarter;
    logic                 all_ram;
    logic [1:0]           rompage;
    logic                 lock;
    logic [BANK_BITS-1:0] bank;
    logic [BANK_BITS-1:0] qbank;
    logic [2:0]           fixed_bank;
    logic                 use_bank;
    logic                 is_ram;
    logic                 is_1ffd;
    logic                 is_7ffd;
    logic                 commit;

    assign quarter = address[15:14];
    assign all_ram = PLUS3_EN & p1ffd[0];
    assign rompage = {p1ffd[2] & PLUS3_EN, p7ffd[4]};
    // On 1024K boards bit 5 is a bank bit, so it cannot also be the lock.
    assign lock    = p7ffd[5] & (BANK_BITS != 6);
    assign bank    = BANK_BITS'({p7ffd[5] & (BANK_BITS == 6), p7ffd[7:6], p7ffd[2:0]});

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fixed_bank = 3'd0;
        use_bank   = 1'b0;
        is_ram     = 1'b1;
        if (all_ram) begin
            case (p1ffd[2:1])
                2'b00:   fixed_bank = {1'b0, quarter};
                2'b01:   fixed_bank = {1'b1, quarter};
                2'b10:   fixed_bank = (quarter == 2'd3) ? 3'd3 : {1'b1, quarter};
                default: begin
                    case (quarter)
                        2'd0:    fixed_bank = 3'd4;
                        2'd1:    fixed_bank = 3'd7;
                        2'd2:    fixed_bank = 3'd6;
                        default: fixed_bank = 3'd3;
                    endcase
                end
            endcase
        end else begin
            case (quarter)
                2'd0:    is_ram     = 1'b0;
                2'd1:    fixed_bank = 3'd5;
                2'd2:    fixed_bank = 3'd2;
                default: use_bank   = 1'b1;
            endcase
        end
    end

    assign qbank       = use_bank ? bank : BANK_BITS'(fixed_bank);
    assign ram_address = {qbank, address[13:0]};
    assign rom_address = {rompage, address[13:0]};
    assign ram_we      = we & hold & is_ram;
    assign i_data      = is_ram ? ram_idata : (trdos ? trdos_idata : rom_idata);

    assign is_1ffd    = PLUS3_EN & (address[15:12] == 4'b0001) & (address[1:0] == 2'b01);
    assign is_7ffd    = ~is_1ffd & ~address[15] & (address[1:0] == 2'b01);
    assign port_hit   = is_1ffd | is_7ffd;
    assign port_rdata = is_1ffd ? p1ffd : (is_7ffd ? p7ffd : 8'h00);

    assign vidpage = p7ffd[3];
    assign trdos   = (state == ST_DOS);
    assign commit  = portwe & hold & ~pw_q;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            p7ffd  <= 8'h00;
            p1ffd  <= 8'h00;
            border <= 3'd0;
            state  <= ST_NORMAL;
            // A write still held across reset must not commit once reset lifts.
            pw_q   <= portwe & hold;
        end else begin
            pw_q <= portwe & hold;
            if (commit) begin
                if (is_1ffd) begin
                    if (!lock) p1ffd <= o_data;
                end else if (is_7ffd) begin
                    if (!lock) p7ffd <= o_data;
                end else if (!address[0]) begin
                    border <= o_data[2:0];
                end
            end
            if (!TRDOS_EN || all_ram) begin
                state <= ST_NORMAL;
            end else if (hold && m0) begin
                if (state == ST_NORMAL) begin
                    if (address[15:8] == 8'h3D && rompage == ROM_TOP) state <= ST_DOS;
                end else if (address[15:14] != 2'b00) begin
                    state <= ST_NORMAL;
                end
            end
        end
    end

endmodule

// File: tb/tb_zx_mmap_ext.sv
// Bench for zx_mmap_ext: three configurations (Pentagon-512, +3 128K, 1024K without
// TR-DOS) driven in parallel, checked against a behavioural map model.
module tb_zx_mmap_ext;

    logic        clock = 1'b0;
    logic        reset_n, m0, hold, we, portwe;
    logic [15:0] address;
    logic [7:0]  o_data, rom_idata, trdos_idata, ram_idata;

    logic [7:0]  i_data_x[3];
    logic [15:0] rom_addr_x[3];
    logic        ram_we_x[3];
    logic [7:0]  port_rdata_x[3];
    logic        port_hit_x[3];
    logic        vidpage_x[3];
    logic [2:0]  border_x[3];
    logic        trdos_x[3];
    logic [18:0] ram_addr_a;
    logic [16:0] ram_addr_b;
    logic [19:0] ram_addr_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Model configuration and architectural state, one slot per instance.
    int       m_bb[3] = '{5, 3, 6};
    bit       m_p3[3] = '{1'b0, 1'b1, 1'b0};
    bit       m_te[3] = '{1'b1, 1'b1, 1'b0};
    int       ram_tbl[4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{4, 5, 6, 3}, '{4, 7, 6, 3}};
    bit [7:0] m_p7[3];
    bit [7:0] m_p1[3];
    bit [2:0] m_border[3];
    bit       m_dos[3];
    bit       m_pw[3];

    always #5 clock = ~clock;

    zx_mmap_ext #(.BANK_BITS(5), .PLUS3_EN(1'b0), .TRDOS_EN(1'b1)) dut_a (
        .clock(clock), .reset_n(reset_n), .m0(m0), .hold(hold), .address(address), .we(we),
        .portwe(portwe), .o_data(o_data), .rom_idata(rom_idata), .trdos_idata(trdos_idata),
        .ram_idata(ram_idata), .i_data(i_data_x[0]), .rom_address(rom_addr_x[0]),
        .ram_address(ram_addr_a), .ram_we(ram_we_x[0]), .port_rdata(port_rdata_x[0]),
        .port_hit(port_hit_x[0]), .vidpage(vidpage_x[0]), .border(border_x[0]), .trdos(trdos_x[0]));

    zx_mmap_ext #(.BANK_BITS(3), .PLUS3_EN(1'b1), .TRDOS_EN(1'b1)) dut_b (
        .clock(clock), .reset_n(reset_n), .m0(m0), .hold(hold), .address(address), .we(we),
        .portwe(portwe), .o_data(o_data), .rom_idata(rom_idata), .trdos_idata(trdos_idata),
        .ram_idata(ram_idata), .i_data(i_data_x[1]), .rom_address(rom_addr_x[1]),
        .ram_address(ram_addr_b), .ram_we(ram_we_x[1]), .port_rdata(port_rdata_x[1]),
        .port_hit(port_hit_x[1]), .vidpage(vidpage_x[1]), .border(border_x[1]), .trdos(trdos_x[1]));

    zx_mmap_ext #(.BANK_BITS(6), .PLUS3_EN(1'b0), .TRDOS_EN(1'b0)) dut_c (
        .clock(clock), .reset_n(reset_n), .m0(m0), .hold(hold), .address(address), .we(we),
        .portwe(portwe), .o_data(o_data), .rom_idata(rom_idata), .trdos_idata(trdos_idata),
        .ram_idata(ram_idata), .i_data(i_data_x[2]), .rom_address(rom_addr_x[2]),
        .ram_address(ram_addr_c), .ram_we(ram_we_x[2]), .port_rdata(port_rdata_x[2]),
        .port_hit(port_hit_x[2]), .vidpage(vidpage_x[2]), .border(border_x[2]), .trdos(trdos_x[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Physical bank behind a 16K quarter, or -1 when the quarter is ROM.
    function automatic int quarter_bank(input int k, input int q);
        int sel;
        if (m_p3[k] && m_p1[k][0]) return ram_tbl[m_p1[k][2:1]][q];
        if (q == 0) return -1;
        if (q == 1) return 5;
        if (q == 2) return 2;
        sel = m_p7[k][7:6] * 8 + m_p7[k][2:0] + ((m_bb[k] == 6) ? m_p7[k][5] * 32 : 0);
        return sel % (1 << m_bb[k]);
    endfunction

    // 0 = none, 1 = 7FFD, 2 = 1FFD, 3 = border
    function automatic int port_sel(input int k, input logic [15:0] a);
        if (m_p3[k] && a[15:12] == 4'h1 && a[1:0] == 2'b01) return 2;
        if (!a[15] && a[1:0] == 2'b01) return 1;
        if (!a[0]) return 3;
        return 0;
    endfunction

    function automatic int rom_page(input int k);
        return ((m_p3[k] && m_p1[k][2]) ? 2 : 0) + m_p7[k][4];
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            int          b;
            int          ps;
            logic [31:0] ra;
            b  = quarter_bank(k, address[15:14]);
            ps = port_sel(k, address);
            ra = (k == 0) ? 32'(ram_addr_a) : (k == 1) ? 32'(ram_addr_b) : 32'(ram_addr_c);
            check($sformatf("rom_address[%0d]", k), rom_addr_x[k], rom_page(k) * 16384 + address[13:0]);
            if (b >= 0) check($sformatf("ram_address[%0d]", k), ra, b * 16384 + address[13:0]);
            check($sformatf("ram_we[%0d]", k), ram_we_x[k], we && hold && b >= 0);
            check($sformatf("i_data[%0d]", k), i_data_x[k],
                  (b >= 0) ? ram_idata : (m_dos[k] ? trdos_idata : rom_idata));
            check($sformatf("port_hit[%0d]", k), port_hit_x[k], ps == 1 || ps == 2);
            if (ps == 1) check($sformatf("rd7ffd[%0d]", k), port_rdata_x[k], m_p7[k]);
            if (ps == 2) check($sformatf("rd1ffd[%0d]", k), port_rdata_x[k], m_p1[k]);
            check($sformatf("vidpage[%0d]", k), vidpage_x[k], m_p7[k][3]);
            check($sformatf("border[%0d]", k), border_x[k], m_border[k]);
            check($sformatf("trdos[%0d]", k), trdos_x[k], m_dos[k]);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit [7:0] p7o, p1o;
            int       ps;
            int       page;
            bit       all_ram;
            p7o = m_p7[k];
            p1o = m_p1[k];
            if (!reset_n) begin
                m_p7[k] = 0; m_p1[k] = 0; m_border[k] = 0; m_dos[k] = 0;
                m_pw[k] = portwe && hold;
            end else begin
                ps      = port_sel(k, address);
                page    = rom_page(k);
                all_ram = m_p3[k] && p1o[0];
                if (portwe && hold && !m_pw[k]) begin
                    if (ps == 3) m_border[k] = o_data[2:0];
                    else if (!(p7o[5] && m_bb[k] != 6)) begin
                        if (ps == 1) m_p7[k] = o_data;
                        if (ps == 2) m_p1[k] = o_data;
                    end
                end
                m_pw[k] = portwe && hold;
                if (!m_te[k] || all_ram) m_dos[k] = 0;
                else if (hold && m0) begin
                    if (!m_dos[k] && address[15:8] == 8'h3D && page == (m_p3[k] ? 3 : 1)) m_dos[k] = 1;
                    else if (m_dos[k] && address[15:14] != 2'b00) m_dos[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        #2;
        check_outputs();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic out_port(input logic [15:0] a, input logic [7:0] d);
        portwe = 1'b1; address = a; o_data = d;
        tick();
        portwe = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int pw_left = 0;
        reset_n = 1'b0; m0 = 1'b0; hold = 1'b1; we = 1'b0; portwe = 1'b0;
        address = 16'h0000; o_data = 8'h00;
        rom_idata = 8'hA5; trdos_idata = 8'h5A; ram_idata = 8'h3C;
        @(posedge clock);
        model_edge();
        #1;
        do_reset();

        // Reset state reads
        address = 16'h0000; #1;
        check("rst_rom_data", i_data_x[0], 8'hA5);
        check("rst_rom_addr", rom_addr_x[0], 16'h0000);
        address = 16'hC000; #1;
        check("rst_ram_addr", ram_addr_a, 19'h00000);
        check("rst_vidpage", vidpage_x[0], 1'b0);
        tick();

        // Pentagon-512: held write commits only once
        portwe = 1'b1; address = 16'h7FFD; o_data = 8'hC3; tick();
        o_data = 8'h01; tick(); tick();
        portwe = 1'b0; tick();
        address = 16'hC123; #1;
        check("p512_ram_addr", ram_addr_a, 19'h6C123);
        check("p128_ram_addr", ram_addr_b, 17'h0C123);
        check("p1024_ram_addr", ram_addr_c, 20'h6C123);
        address = 16'h7FFD; #1;
        check("p512_readback", port_rdata_x[0], 8'hC3);
        check("p512_hit", port_hit_x[0], 1'b1);
        tick();

        // Lock
        do_reset();
        out_port(16'h7FFD, 8'h27);
        out_port(16'h7FFD, 8'h01);
        address = 16'hC000; #1;
        check("lock_bank_b", ram_addr_b, 17'h1C000);
        check("lock_bank_a", ram_addr_a, 19'h1C000);
        address = 16'h7FFD; #1;
        check("lock_readback", port_rdata_x[1], 8'h27);
        check("nolock_1024k", port_rdata_x[2], 8'h01);
        tick();

        // +3 all-RAM mode 10
        do_reset();
        out_port(16'h1FFD, 8'h05);
        address = 16'h0000; we = 1'b1; #1;
        check("p3_q0_we", ram_we_x[1], 1'b1);
        check("p3_q0_bank", ram_addr_b, 17'h10000);
        check("p3_q0_rom_a", ram_we_x[0], 1'b0);
        tick();
        we = 1'b0; address = 16'h4000; #1;
        check("p3_q1_bank", ram_addr_b, 17'h14000);
        address = 16'hC000; #1;
        check("p3_q3_bank", ram_addr_b, 17'h0C000);
        address = 16'h1FFD; #1;
        check("p3_readback", port_rdata_x[1], 8'h05);
        tick();

        // TR-DOS entry and exit
        do_reset();
        out_port(16'h7FFD, 8'h10);
        m0 = 1'b1; address = 16'h3D2F; #1;
        check("dos_fetch_old_rom", i_data_x[0], 8'hA5);
        check("dos_before", trdos_x[0], 1'b0);
        tick();
        m0 = 1'b0; address = 16'h0000; #1;
        check("dos_entered", trdos_x[0], 1'b1);
        check("dos_rom_data", i_data_x[0], 8'h5A);
        check("dos_p3_not_top", trdos_x[1], 1'b0);
        check("dos_disabled", trdos_x[2], 1'b0);
        tick();
        address = 16'h8000; tick();
        check("dos_data_read", trdos_x[0], 1'b1);
        m0 = 1'b1; tick();
        m0 = 1'b0; #1;
        check("dos_exit", trdos_x[0], 1'b0);
        out_port(16'h7FFD, 8'h00);
        m0 = 1'b1; address = 16'h3D2F; tick();
        m0 = 1'b0; #1;
        check("dos_page0", trdos_x[0], 1'b0);

        // Border
        out_port(16'h00FE, 8'h05);
        check("border_val", border_x[0], 3'd5);
        address = 16'h00FE; #1;
        check("border_no_hit", port_hit_x[0], 1'b0);
        address = 16'h7FFD; #1;
        check("border_p7_same", port_rdata_x[0], 8'h00);
        tick();

        // Write held across reset
        portwe = 1'b1; address = 16'h7FFD; o_data = 8'h08;
        do_reset();
        tick(); tick();
        check("rst_held_write", vidpage_x[0], 1'b0);
        portwe = 1'b0; tick();
        out_port(16'h7FFD, 8'h08);
        check("post_rst_write", vidpage_x[0], 1'b1);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            reset_n     = ($urandom_range(0, 199) != 0);
            rom_idata   = 8'($urandom);
            trdos_idata = 8'($urandom);
            ram_idata   = 8'($urandom);
            we          = 1'($urandom);
            if (pw_left > 0) begin
                pw_left--;
                hold   = 1'b1;
                portwe = (pw_left != 0);
                m0     = 1'b0;
            end else begin
                hold = ($urandom_range(0, 7) != 0);
                r    = $urandom_range(0, 9);
                m0   = 1'b0;
                if (r < 3) begin
                    case ($urandom_range(0, 3))
                        0: address = 16'h7FFD;
                        1: address = 16'h1FFD;
                        2: address = 16'h00FE;
                        default: address = 16'($urandom);
                    endcase
                    o_data = 8'($urandom);
                    if ($urandom_range(0, 7) != 0) o_data[5] = 1'b0;
                    portwe  = 1'b1;
                    pw_left = $urandom_range(1, 3);
                end else if (r < 6) begin
                    m0      = 1'b1;
                    address = ($urandom_range(0, 1) != 0) ? {8'h3D, 8'($urandom)} : 16'($urandom);
                end else begin
                    address = 16'($urandom);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
